out_port_arb: RTL and testbench
===============================

# out_port_arb

Round-robin allocator for one router output port. It collects per-input-port requests from the five XY route-computation units (north, east, south, west, local) that target this output. It grants the port to one requester and holds that grant for the whole packet until the tail flit transfers. One instance sits in front of each output port's crossbar mux select and downstream buffer.

## Interface
Parameters:
- NUM_REQ, 5, number of requesting input ports; index order N=0, E=1, S=2, W=3, L=4
- TIMEOUT_CYC, 16, stall cycles before a forced release; used only with the timeout feature; legal range 2..255

Ports:
- clk_i  in  1  single clock, rising edge
- rst_n_i  in  1  reset, asynchronous assert, active-low
- req_i  in  NUM_REQ  request from each input port for this output; valid flit present and routed here
- tail_i  in  NUM_REQ  flit presented by each requester is a tail flit; single-flit packets have head = tail
- out_ready_i  in  1  downstream buffer accepts a flit this cycle
- grant_o  out  NUM_REQ  one-hot owner of the port; crossbar select
- grant_valid_o  out  1  port is owned
- xfer_o  out  1  flit transfers this cycle
- timeout_o  out  1  one-cycle pulse on a forced release; constant 0 without the feature

## Operation
- Two states: IDLE and LOCKED. The state register holds the owner index and the round-robin pointer ptr.
- Reset values:
  - state IDLE, ptr 0, owner 0
  - grant_o 0, grant_valid_o 0, xfer_o 0, timeout_o 0
  - stall counter 0
- IDLE behaviour:
  - If req_i is nonzero, select the first set bit searching ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - Register the selection as owner and enter LOCKED.
  - If req_i is zero, stay in IDLE.
- LOCKED outputs:
  - grant_o = one-hot(owner), grant_valid_o = 1.
  - xfer_o = req_i[owner] & out_ready_i. This is combinational.
- LOCKED transitions:
  - Transfer with tail_i[owner]=1: next state IDLE, ptr ← (owner+1) mod NUM_REQ.
  - Transfer with tail_i[owner]=0: stay LOCKED.
  - req_i[owner] low (upstream bubble mid-packet): stay LOCKED, no transfer. The grant is never dropped mid-packet.
- Requests from non-owners during LOCKED are ignored. No queueing; they are rearbitrated at the next IDLE.
- Pointer wrap: owner = NUM_REQ-1 releases to ptr = 0.
- Wormhole guarantee: flits of different packets never interleave on the port.

## Timing
- Request to grant: 1 cycle. req_i sampled in IDLE at edge T gives grant_o valid from T+1.
- Transfer is same-cycle. xfer_o is asserted in the cycle req_i[owner] and out_ready_i are both high.
- Release: a tail transfer at cycle T puts the block in IDLE at T+1. A new grant is visible at T+2, so there is one bubble cycle between packets.
- Simultaneous tail transfer and new requests: the new requests are not granted in cycle T. They are arbitrated in the T+1 IDLE cycle using the updated ptr.
- Reset asserted mid-packet: all state clears immediately. No transfer completes in that cycle.
- out_ready_i low for any number of cycles: the grant is held and xfer_o stays 0. Only the timeout feature can release it.

## Configuration
- Macro OUT_PORT_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit stall counter increments on each LOCKED cycle with xfer_o=0 and clears on any transfer and on entering LOCKED.
  - When the counter reaches TIMEOUT_CYC-1, the block is forced to IDLE on the next edge, ptr ← (owner+1) mod NUM_REQ, and timeout_o pulses high for that one cycle.
- Undefined: no counter, timeout_o tied to 0, and the lock holds indefinitely.

## Structure
- Shared package noc_pkg contains:
  - NUM_PORTS = 5
  - port index enum (PORT_N, PORT_E, PORT_S, PORT_W, PORT_L)
  - arbiter state typedef arb_state_t {ARB_IDLE, ARB_LOCKED}
- Sub-module rr_pick: combinational. Inputs are req vector and ptr. Outputs are a one-hot pick and a found flag. It is reused by other allocators.

## Test plan
- Reset: hold rst_n_i=0 with req_i=5'b11111 → all outputs 0. Release → grant_o=5'b00001 one cycle later.
- Single-flit fairness: all five request continuously with tail_i all 1 and out_ready_i=1 → grants N, E, S, W, L, N in order, each separated by one idle cycle.
- Multi-flit lock: E sends a 4-flit packet with tail on the 4th flit while S requests throughout → grant_o=00010 for 4 transfers, then 00100.
- Backpressure and bubble: owner W, out_ready_i low for 5 cycles and req_i[W] low for 2 cycles mid-packet → xfer_o=0 in those cycles, grant held, no extra flits counted.
- Timeout, macro defined, TIMEOUT_CYC=4: owner L with out_ready_i held 0 → timeout_o pulses on the 4th stall cycle, next state IDLE, ptr=0, N granted next.
- Mid-packet reset: assert rst_n_i during the second flit of a 3-flit packet → outputs 0 immediately. After release, arbitration restarts from ptr=0.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared router-level types: port indices and allocator state encoding.
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int STALL_W   = 8;

    typedef enum logic [2:0] {
        PORT_N = 3'd0,
        PORT_E = 3'd1,
        PORT_S = 3'd2,
        PORT_W = 3'd3,
        PORT_L = 3'd4
    } port_e;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import noc_pkg::*;
#(
    parameter int N  = NUM_PORTS,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  pick_o,
    output logic          found_o
);

    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // Walk offsets from farthest to nearest so the closest request to ptr wins.
    always_comb begin
        pick_o  = '0;
        found_o = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int off = N - 1; off >= 0; off--) begin
            sum = {1'b0, ptr_i} + (IW + 1)'(off);
            if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
            idx = sum[IW-1:0];
            if (req_i[idx]) begin
                pick_o      = '0;
                pick_o[idx] = 1'b1;
                found_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/out_port_arb.sv
// Output-port wormhole allocator: round-robin grant held until the tail flit moves.
// Optional stall-timeout release enabled with `define OUT_PORT_ARB_TIMEOUT_EN.
module out_port_arb
    import noc_pkg::*;
#(
    parameter int NUM_REQ     = NUM_PORTS,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] tail_i,
    input  logic               out_ready_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_valid_o,
    output logic               xfer_o,
    output logic               timeout_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   pick_idx, next_ptr;
    logic [NUM_REQ-1:0] pick;
    logic               found;
    logic               locked;
    logic               force_rel;

    rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
        .req_i   (req_i),
        .ptr_i   (ptr_q),
        .pick_o  (pick),
        .found_o (found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (pick[i]) pick_idx = IDX_W'(i);
    end

    assign locked        = (state_q == ARB_LOCKED);
    assign next_ptr      = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    assign grant_o       = locked ? (NUM_REQ'(1) << owner_q) : '0;
    assign grant_valid_o = locked;
    assign xfer_o        = locked & req_i[owner_q] & out_ready_i;

`ifdef OUT_PORT_ARB_TIMEOUT_EN
    logic [STALL_W-1:0] stall_q, stall_d;

    // Counter sits at zero while idle, so entering LOCKED always starts a fresh count.
    always_comb begin
        stall_d   = stall_q;
        force_rel = 1'b0;
        if (!locked || xfer_o) begin
            stall_d = '0;
        end else if (stall_q == STALL_W'(TIMEOUT_CYC - 1)) begin
            force_rel = 1'b1;
            stall_d   = '0;
        end else begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) stall_q <= '0;
        else          stall_q <= stall_d;
    end
`else
    assign force_rel = 1'b0;
`endif

    assign timeout_o = force_rel;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    state_d = ARB_LOCKED;
                    owner_d = pick_idx;
                end
            end
            ARB_LOCKED: begin
                if ((xfer_o && tail_i[owner_q]) || force_rel) begin
                    state_d = ARB_IDLE;
                    ptr_d   = next_ptr;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_out_port_arb.sv
// Randomized + directed bench for out_port_arb against an integer-level allocator model.
module tb_out_port_arb;

`ifdef OUT_PORT_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
    localparam int TCYC  = 4;
`else
    localparam bit TO_EN = 1'b0;
    localparam int TCYC  = 16;
`endif
    localparam int NR = 5;

    logic          clk_i = 1'b0;
    logic          rst_n_i;
    logic [NR-1:0] req_i, tail_i;
    logic          out_ready_i;
    logic [NR-1:0] grant_o;
    logic          grant_valid_o, xfer_o, timeout_o;

    out_port_arb #(.NUM_REQ(NR), .TIMEOUT_CYC(TCYC)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .req_i         (req_i),
        .tail_i        (tail_i),
        .out_ready_i   (out_ready_i),
        .grant_o       (grant_o),
        .grant_valid_o (grant_valid_o),
        .xfer_o        (xfer_o),
        .timeout_o     (timeout_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: who holds the port, where the round-robin search starts next.
    bit m_locked;
    int m_owner, m_ptr, m_stall;
    int grant_log[$];
    int dut_xfers, mdl_xfers;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void m_reset();
        m_locked = 1'b0;
        m_owner  = 0;
        m_ptr    = 0;
        m_stall  = 0;
    endfunction

    // One cycle: drive at negedge, check outputs, advance model on posedge.
    task automatic step(input logic [NR-1:0] r, input logic [NR-1:0] t, input logic rdy);
        bit ex, et;
        int eg;
        req_i = r; tail_i = t; out_ready_i = rdy;
        #1;
        ex = m_locked && r[m_owner] && rdy;
        et = TO_EN && m_locked && !ex && (m_stall == TCYC - 1);
        eg = m_locked ? (1 << m_owner) : 0;
        chk("grant",   32'(grant_o),       32'(eg));
        chk("gvalid",  32'(grant_valid_o), 32'(m_locked));
        chk("xfer",    32'(xfer_o),        32'(ex));
        chk("timeout", 32'(timeout_o),     32'(et));
        if (xfer_o === 1'b1) dut_xfers++;
        if (ex) mdl_xfers++;
        @(posedge clk_i);
        if (!m_locked) begin
            for (int k = 0; k < NR; k++) begin
                if (r[(m_ptr + k) % NR]) begin
                    m_locked = 1'b1;
                    m_owner  = (m_ptr + k) % NR;
                    m_stall  = 0;
                    grant_log.push_back(m_owner);
                    break;
                end
            end
        end else if ((ex && t[m_owner]) || et) begin
            m_locked = 1'b0;
            m_ptr    = (m_owner + 1) % NR;
            m_stall  = 0;
        end else if (ex) begin
            m_stall = 0;
        end else begin
            m_stall++;
        end
        @(negedge clk_i);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && m_locked; i++)
            step(NR'(1) << m_owner, NR'(1) << m_owner, 1'b1);
        chk("drain_idle", 32'(grant_valid_o), 32'd0);
    endtask

    initial begin
        logic [NR-1:0] r, t;
        logic rdy;

        // Reset held with every port requesting: nothing may be granted.
        rst_n_i = 1'b0; req_i = '1; tail_i = '1; out_ready_i = 1'b1;
        m_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_grant",  32'(grant_o),       32'd0);
        chk("rst_gvalid", 32'(grant_valid_o), 32'd0);
        chk("rst_xfer",   32'(xfer_o),        32'd0);
        chk("rst_to",     32'(timeout_o),     32'd0);
        rst_n_i = 1'b1;

        // Single-flit fairness: N,E,S,W,L,N with an idle cycle between packets.
        grant_log.delete();
        repeat (12) step('1, '1, 1'b1);
        chk("fair_cnt", 32'(grant_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < grant_log.size(); i++)
            chk("fair_order", 32'(grant_log[i]), 32'(i % NR));

        // Four-flit packet from E while S keeps requesting.
        grant_log.delete();
        dut_xfers = 0; mdl_xfers = 0;
        step(5'b00110, 5'b00100, 1'b1);
        for (int f = 1; f <= 4; f++)
            step(5'b00110, (f == 4) ? 5'b00110 : 5'b00100, 1'b1);
        chk("e_flits", 32'(dut_xfers), 32'd4);
        step(5'b00100, 5'b00100, 1'b1);
        step(5'b00100, 5'b00100, 1'b1);
        chk("e_then_s0", 32'(grant_log[0]), 32'(1));
        chk("e_then_s1", 32'(grant_log[1]), 32'(2));

        // W packet with backpressure and an upstream bubble mid-packet.
        dut_xfers = 0; mdl_xfers = 0;
        step(5'b01000, 5'b00000, 1'b1);
        step(5'b01000, 5'b00000, 1'b1);
        repeat (5) step(5'b01000, 5'b00000, 1'b0);
        repeat (2) step(5'b00000, 5'b00000, 1'b1);
        step(5'b01000, 5'b00000, 1'b1);
        step(5'b01000, 5'b01000, 1'b1);
        chk("w_flits", 32'(dut_xfers), 32'(mdl_xfers));
        drain();

        // Stall an L packet to exercise the forced-release path.
        step(5'b10000, 5'b00000, 1'b1);
        repeat (TCYC + 2) step(5'b10001, 5'b00000, 1'b0);
        drain();

        // Reset during the second flit of a three-flit N packet.
        step(5'b00001, 5'b00000, 1'b1);
        step(5'b00001, 5'b00000, 1'b1);
        req_i = 5'b00001; tail_i = 5'b00000; out_ready_i = 1'b1;
        #1 chk("mid_xfer_pre", 32'(xfer_o), 32'd1);
        #1 rst_n_i = 1'b0;
        #1;
        chk("mid_grant",  32'(grant_o),       32'd0);
        chk("mid_gvalid", 32'(grant_valid_o), 32'd0);
        chk("mid_xfer",   32'(xfer_o),        32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        m_reset();
        grant_log.delete();
        step(5'b11001, 5'b11111, 1'b1);
        step(5'b11001, 5'b11111, 1'b1);
        chk("restart_ptr0", 32'(grant_log[0]), 32'd0);

        // Random traffic; low-ready phase stresses long stalls.
        for (int i = 0; i < 3000; i++) begin
            r   = NR'($urandom);
            t   = NR'($urandom) | NR'($urandom);
            rdy = (i < 2000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            step(r, t, rdy);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
